// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader FSM states, the header length width and the legal-length rule live here.
package imem_loader_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StData,
    StDone,
    StErr
  } state_e;

  // A header is usable only if it asks for at least one word and fits the memory.
  function automatic logic len_legal(logic [LEN_W-1:0] len, int unsigned depth);
    return (len != '0) && (32'(len) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words.
// word_valid_o pulses combinationally while the fourth byte of a word is being accepted.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic [1:0]        byte_idx_o
);

  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;

  // word_o merges the incoming byte so the completed word is usable in the accepting cycle.
  always_comb begin
    word_o                             = asm_q;
    word_o[{byte_idx_q, 3'b000} +: 8]  = byte_i;
    word_valid_o                       = byte_valid_i && !clear_i && (byte_idx_q == 2'd3);
    asm_d                              = asm_q;
    byte_idx_d                         = byte_idx_q;
    if (clear_i) begin
      asm_d      = '0;
      byte_idx_d = '0;
    end else if (byte_valid_i) begin
      asm_d      = word_o;
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      asm_q      <= '0;
      byte_idx_q <= '0;
    end else begin
      asm_q      <= asm_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign byte_idx_o = byte_idx_q;

endmodule

// File: rtl/imem_loader.sv
// Run-time program loader: length-prefixed byte stream in, instruction-memory word writes out.
// Keeps the core in reset until every word of the program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_full;
  logic [ADDR_W-1:0]  word_addr_q, word_addr_d;
  logic [LEN_W-1:0]   words_loaded_q, words_loaded_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               done_q, done_d;
  logic               core_rst_q, core_rst_d;

  logic               accept;
  logic               asm_valid;
  logic               asm_clear;
  logic               word_valid;
  logic [WORD_W-1:0]  word;
  logic [1:0]         byte_idx;

  // start wins over a byte offered in the same cycle.
  assign in_ready  = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign accept    = in_valid && in_ready && !start;
  assign asm_valid = accept && (state_q == StData);
  assign asm_clear = start || (accept && (state_q == StLenHi));
  assign len_full  = {in_data, len_q[7:0]};

  word_assembler u_word_assembler (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word),
    .byte_idx_o   (byte_idx)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    word_addr_d    = word_addr_q;
    words_loaded_d = words_loaded_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    // done/core_rst lag the state by one cycle so the last write lands before the core runs.
    done_d         = (state_q == StDone);
    core_rst_d     = (state_q != StDone);

    if (start) begin
      state_d        = StLenLo;
      word_addr_d    = '0;
      words_loaded_d = '0;
      done_d         = 1'b0;
      core_rst_d     = 1'b1;
    end else begin
      unique case (state_q)
        StLenLo: begin
          if (accept) begin
            len_d[7:0] = in_data;
            state_d    = StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_d = len_full;
            if (len_legal(len_full, DEPTH)) begin
              state_d        = StData;
              word_addr_d    = '0;
              words_loaded_d = '0;
            end else begin
              state_d = StErr;
            end
          end
        end
        StData: begin
          if (word_valid) begin
            mem_we_d       = 1'b1;
            mem_wdata_d    = word;
            mem_addr_d     = word_addr_q;
            word_addr_d    = word_addr_q + ADDR_W'(1);
            words_loaded_d = words_loaded_q + LEN_W'(1);
            if (words_loaded_q + LEN_W'(1) == len_q) begin
              state_d = StDone;
            end
          end
        end
        StDone: ;
        StErr:  ;
        default: state_d = StLenLo;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StLenLo;
      len_q          <= '0;
      word_addr_q    <= '0;
      words_loaded_q <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      done_q         <= 1'b0;
      core_rst_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      word_addr_q    <= word_addr_d;
      words_loaded_q <= words_loaded_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      done_q         <= done_d;
      core_rst_q     <= core_rst_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign error        = (state_q == StErr);
  assign words_loaded = words_loaded_q;

  logic unused_byte_idx;
  assign unused_byte_idx = ^byte_idx;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, gaps, bad headers, restart and async reset.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  logic [7:0] prog [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

  imem_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_rst     (core_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(32'(mem_addr));
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; presents one byte for the next rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_prog(input int gap);
    for (int i = 0; i < 10; i++) send(prog[i], gap);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic chk_two_writes(input string tag, input int spacing);
    chk({tag, "_nwr"}, 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk({tag, "_addr0"}, log_addr[0], 32'd0);
      chk({tag, "_data0"}, log_data[0], 32'h00A00513);
      chk({tag, "_addr1"}, log_addr[1], 32'd1);
      chk({tag, "_data1"}, log_data[1], 32'h00100593);
      chk({tag, "_spacing"}, 32'(log_cyc[1] - log_cyc[0]), 32'(spacing));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Normal load, back-to-back bytes
    clear_log();
    send_prog(0);
    chk("norm_we_last", 32'(mem_we), 32'd1);
    chk("norm_addr_last", 32'(mem_addr), 32'd1);
    chk("norm_data_last", mem_wdata, 32'h00100593);
    chk("norm_done_early", 32'(done), 32'd0);
    chk("norm_crst_early", 32'(core_rst), 32'd1);
    chk("norm_ready_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("norm_done", 32'(done), 32'd1);
    chk("norm_crst", 32'(core_rst), 32'd0);
    chk("norm_we_off", 32'(mem_we), 32'd0);
    chk("norm_words", 32'(words_loaded), 32'd2);
    chk_two_writes("norm", 4);

    // start while DONE
    pulse_start();
    chk("sdone_crst", 32'(core_rst), 32'd1);
    chk("sdone_done", 32'(done), 32'd0);
    chk("sdone_ready", 32'(in_ready), 32'd1);
    chk("sdone_words", 32'(words_loaded), 32'd0);

    // Same stream with 3 idle cycles between bytes
    clear_log();
    send_prog(3);
    chk_two_writes("gap", 16);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_words", 32'(words_loaded), 32'd2);

    // Zero-length header
    pulse_start();
    clear_log();
    send(8'h00, 0);
    send(8'h00, 0);
    in_valid = 1'b0;
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_ready", 32'(in_ready), 32'd0);
    chk("len0_crst", 32'(core_rst), 32'd1);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("len0_stuck", 32'(error), 32'd1);
    chk("len0_nwr", 32'(log_addr.size()), 32'd0);
    chk("len0_done", 32'(done), 32'd0);

    // 257 words exceeds DEPTH
    pulse_start();
    chk("err_clear", 32'(error), 32'd0);
    send(8'h01, 0);
    send(8'h01, 0);
    in_valid = 1'b0;
    chk("len257_error", 32'(error), 32'd1);
    chk("len257_ready", 32'(in_ready), 32'd0);
    chk("len257_crst", 32'(core_rst), 32'd1);
    @(negedge clk);
    chk("len257_nwr", 32'(log_addr.size()), 32'd0);

    // 256 words is the largest legal header
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    in_valid = 1'b0;
    chk("len256_error", 32'(error), 32'd0);
    chk("len256_ready", 32'(in_ready), 32'd1);

    // Restart after half a word; the byte offered with start must be dropped
    pulse_start();
    clear_log();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h05, 0);
    start    = 1'b1;
    in_data  = 8'h55;
    in_valid = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("rs_ready", 32'(in_ready), 32'd1);
    chk("rs_words", 32'(words_loaded), 32'd0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hEF, 0);
    send(8'hBE, 0);
    send(8'hAD, 0);
    send(8'hDE, 0);
    in_valid = 1'b0;
    chk("rs_we", 32'(mem_we), 32'd1);
    chk("rs_addr", 32'(mem_addr), 32'd0);
    chk("rs_data", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("rs_done", 32'(done), 32'd1);
    chk("rs_crst", 32'(core_rst), 32'd0);
    chk("rs_words_end", 32'(words_loaded), 32'd1);
    chk("rs_nwr", 32'(log_addr.size()), 32'd1);
    if (log_data.size() == 1) chk("rs_logdata", log_data[0], 32'hDEADBEEF);

    // Async reset in the middle of the second word
    pulse_start();
    for (int i = 0; i < 8; i++) send(prog[i], 0);
    in_valid = 1'b0;
    chk("mid_words", 32'(words_loaded), 32'd1);
    chk("mid_wdata", mem_wdata, 32'h00A00513);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_prog(0);
    @(negedge clk);
    chk_two_writes("post", 4);
    chk("post_done", 32'(done), 32'd1);
    chk("post_crst", 32'(core_rst), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes the core's instruction memory at run time, replacing the file preload used in simulation.
- Accepts a length-prefixed little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes each word to consecutive instruction-memory word addresses from 0.
- Holds the riscv core in reset until the load completes, then releases it.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, maximum number of loadable words; must be at most 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; restarts a load from any state.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both 1 on a clock edge.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  instruction word.
- core_rst  output  1  reset to the riscv core; 1 while loading.
- done  output  1  load completed successfully.
- error  output  1  illegal length header.
- words_loaded  output  16  count of words written in the current load.

Behaviour:
- Reset values: state LEN_LO, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, error=0, words_loaded=0.
- State LEN_LO:
  - On an accepted byte, latch len[7:0] and go to LEN_HI.
- State LEN_HI:
  - On an accepted byte, latch len[15:8].
  - If the full len is 0 or greater than DEPTH, go to ERR.
  - Otherwise go to DATA with byte_idx=0 and word_addr=0.
- State DATA:
  - Each accepted byte goes into the assembly register at bits [8*byte_idx+7 : 8*byte_idx], little-endian.
  - byte_idx increments modulo 4.
  - When the 4th byte (byte_idx=3) is accepted, the following are registered and take effect in the next cycle:
    - mem_we=1 for exactly that one cycle.
    - mem_wdata = the fully assembled word.
    - mem_addr = word_addr.
    - word_addr increments.
    - words_loaded increments.
  - The next word's first byte may be accepted in that same cycle; there are no bubbles.
  - If the accepted word is word len-1, go to DONE at the same edge that raises mem_we.
- State DONE:
  - in_ready=0.
  - done=1 and core_rst=0, both from the cycle after the final mem_we pulse, so the final word is written before the core leaves reset.
  - Stays in DONE until start or rst.
- State ERR:
  - in_ready=0, error=1, core_rst=1.
  - No memory writes.
  - Stays in ERR until start or rst.
- in_ready is 1 in LEN_LO, LEN_HI and DATA, and 0 in DONE and ERR.
- in_valid=0 stalls the loader indefinitely. Partial words are kept and no timeout applies.
- start, in any state and taking priority over a simultaneous byte transfer:
  - Go to LEN_LO.
  - Clear byte_idx, word_addr, words_loaded, done and error.
  - core_rst=1 at the next edge.
  - Any pending mem_we is not suppressed; a write registered at that edge completes.
- rst asserted mid-load: all state returns to reset values immediately. Memory contents already written are not cleared.
- Width rules:
  - len and words_loaded are 16-bit.
  - word_addr is ADDR_W bits and never wraps, because len is at most DEPTH.
  - mem_addr for word k is k[ADDR_W-1:0].
- Bytes received while in DONE or ERR are not accepted; in_ready=0.

Decomposition:
- Shared package imem_loader_pkg holds:
  - The state encoding: LEN_LO, LEN_HI, DATA, DONE, ERR.
  - A LEN_W=16 constant.
- One natural sub-module, word_assembler: byte_idx counter, 32-bit shift/assembly register, and a word_valid pulse on the 4th byte.
- The FSM, address counter and core_rst/done logic stay in imem_loader.
- riscv instantiation gains core_rst on its rst and a shared write port on instruction_memory.

Test Plan:
- Normal load:
  - Stimulus: bytes 02 00 13 05 A0 00 93 05 10 00 with in_valid held high.
  - Required response: mem_we pulses with addr 0, data 00A00513, then addr 1, data 00100593. done=1 and core_rst=0 one cycle after the second pulse. words_loaded=2.
- Backpressure/gaps:
  - Stimulus: the same stream with in_valid low for 3 cycles between every byte.
  - Required response: identical writes and data, only later. No extra or missing mem_we pulses.
- Illegal length:
  - Stimulus: header 00 00, then separately header 01 01 (257) with DEPTH=256.
  - Required response: ERR, error=1, in_ready=0, core_rst=1, no mem_we.
- Restart:
  - Stimulus: after 2 bytes of the first word, pulse start, then send header 01 00 and word EF BE AD DE.
  - Required response: one write, addr 0, data DEADBEEF. done=1, words_loaded=1.
- Reset mid-load:
  - Stimulus: assert rst asynchronously between clock edges during DATA.
  - Required response: outputs reach reset values without waiting for a clock edge. A following full load succeeds from addr 0.
- Start with DONE held:
  - Stimulus: pulse start while in DONE.
  - Required response: core_rst=1 and done=0 at the next edge, in_ready=1.
